cosim_loopback_buffered: RTL and testbench
==========================================

Name: cosim_loopback_buffered

Overview:
- Multi-channel cosim loopback between host-to-device and device-to-host endpoint channels.
- Each channel accepts words from a from-host endpoint and buffers them in a small FIFO.
- Each word is resized (extended or truncated) and returned on the matching to-host channel using a valid/ready handshake.
- Per-channel received/sent counters support host-side checking. The block is instantiated in the cosim top beside the manifest block.

Parameters:
- NUM_CH, 2, number of independent loopback channels (1..8).
- IN_WIDTH, 24, bits per from-host word.
- OUT_WIDTH, 32, bits per to-host word.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, >= 2.
- SIGN_EXTEND, 0, 1: sign-extend when OUT_WIDTH > IN_WIDTH; 0: zero-extend.
- CNT_WIDTH, 16, width of each message counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  NUM_CH  per-channel from-host valid.
- in_ready  out  NUM_CH  per-channel from-host ready.
- in_data  in  NUM_CH*IN_WIDTH  from-host words; channel i is in_data[i*IN_WIDTH +: IN_WIDTH].
- out_valid  out  NUM_CH  per-channel to-host valid.
- out_ready  in  NUM_CH  per-channel to-host ready.
- out_data  out  NUM_CH*OUT_WIDTH  to-host words, same slicing as in_data.
- rx_count  out  NUM_CH*CNT_WIDTH  words accepted per channel.
- tx_count  out  NUM_CH*CNT_WIDTH  words delivered per channel.

Behaviour:
- Reset: clk and rst are fixed; rst is synchronous, active-low.
  - rst low at a rising edge clears all FIFO pointers and occupancy, rx_count and tx_count.
  - out_valid is 0 from the first edge with rst low.
  - in_ready is forced 0 combinationally while rst is low.
  - out_data is don't-care while out_valid is 0.
- Reset mid-operation: buffered words are discarded, not delivered. A handshake is not counted at an edge where rst is low.
- Channels are fully independent. No arbitration and no cross-channel ordering.
- Accept:
  - in_ready[i] = rst && !full[i].
  - A word is accepted on a rising edge with in_valid[i] && in_ready[i].
  - The host may hold in_valid with changing data until it is accepted.
- Deliver:
  - out_valid[i] = !empty[i], registered state only; no combinational path from in_valid.
  - out_data[i] is the resized head entry.
  - A word is delivered on a rising edge with out_valid[i] && out_ready[i].
  - out_valid and out_data hold stable while out_ready is low.
- Latency: a word accepted at edge t makes out_valid high in the cycle after edge t. Minimum 1 cycle, no bypass.
- Throughput: 1 word/cycle/channel when out_ready stays high.
- Simultaneous push and pop:
  - Allowed when the FIFO is neither empty nor full; occupancy is unchanged.
  - When full, in_ready is 0, so there is no push even if a pop occurs in the same cycle.
  - When empty, there is no pop.
- Resize, applied at the FIFO output; the FIFO stores IN_WIDTH bits:
  - OUT_WIDTH > IN_WIDTH: upper bits are zeros, or copies of in bit IN_WIDTH-1 when SIGN_EXTEND = 1.
  - OUT_WIDTH == IN_WIDTH: pass-through.
  - OUT_WIDTH < IN_WIDTH: keep the low OUT_WIDTH bits.
- Pointers: log2(FIFO_DEPTH) bits plus one wrap bit.
  - full when the indices are equal and the wrap bits differ.
  - empty when both indices and wrap bits are equal.
  - Wrap-around is seamless.
- Counters: rx_count[i] increments per accept, tx_count[i] per delivery. Both wrap modulo 2^CNT_WIDTH without saturating.
- Invariant: rx_count - tx_count (mod 2^CNT_WIDTH) equals occupancy, and is <= FIFO_DEPTH.

Decomposition:
- Shared package cosim_loopback_pkg:
  - CNT_WIDTH default constant.
  - function resize_word(word, sign_extend) parametrised through localparams.
  - typedef for the counter.
- Sub-module cosim_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push/pop valid-ready pairs, full, empty.
  - Instantiated NUM_CH times in a generate loop, with counters and resize logic around it.

Test Plan:
- Single word: ch0 in_data=24'hABCDEF, out_ready=1 -> out_data ch0=32'h00ABCDEF one cycle after accept; rx_count=tx_count=1.
- Sign-extend: SIGN_EXTEND=1, in=24'h800001 -> out=32'hFF800001. OUT_WIDTH=16, in=24'h123456 -> out=16'h3456.
- Backpressure/full: out_ready=0, push 5 words 1..5 with DEPTH=4.
  - in_ready drops after 4 accepts and rx_count=4.
  - Raise out_ready -> outputs 1,2,3,4, then 5 is accepted and delivered in order.
- Streaming wrap: 20 back-to-back words on ch1 with out_ready=1.
  - 1 word/cycle, order preserved across pointer wrap.
  - ch0 stays out_valid=0 and counters 0.
- Reset mid-stream: 3 words buffered, rst=0 for one edge.
  - out_valid=0, in_ready=0 during reset, counters 0.
  - After release, the next input 24'h000007 emerges as the first output.
- Counter wrap: CNT_WIDTH=4, 17 transfers -> rx_count=tx_count=1.

Source files
------------

// File: rtl/cosim_loopback_pkg.sv
// Shared constants, counter type and word-resize helper for the cosim loopback block.
package cosim_loopback_pkg;

   localparam int DEFAULT_CNT_WIDTH = 16;
   localparam int MAX_WORD_WIDTH    = 64;

   typedef logic [DEFAULT_CNT_WIDTH-1:0] cnt_t;

   // Widths ride in as arguments so one function serves every instance; callers
   // pad the input to MAX_WORD_WIDTH and cast the result down to their out width.
   function automatic logic [MAX_WORD_WIDTH-1:0] resize_word(
      input logic [MAX_WORD_WIDTH-1:0] word,
      input int                        in_width,
      input int                        out_width,
      input logic                      sign_extend
   );
      logic [MAX_WORD_WIDTH-1:0] one;
      logic [MAX_WORD_WIDTH-1:0] in_mask;
      logic [MAX_WORD_WIDTH-1:0] out_mask;
      logic [MAX_WORD_WIDTH-1:0] ext;
      logic                      msb;
      one      = {{(MAX_WORD_WIDTH-1){1'b0}}, 1'b1};
      in_mask  = (in_width  >= MAX_WORD_WIDTH) ? '1 : ((one << in_width)  - one);
      out_mask = (out_width >= MAX_WORD_WIDTH) ? '1 : ((one << out_width) - one);
      msb      = (word & (one << (in_width - 1))) != '0;
      ext      = (sign_extend && msb) ? ~in_mask : '0;
      return ((word & in_mask) | ext) & out_mask;
   endfunction

endpackage

// File: rtl/cosim_sync_fifo.sv
// Single-clock FIFO with valid/ready push and pop sides; pointers carry one wrap bit.
module cosim_sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_fire;
   logic             pop_fire;

   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty = (wr_ptr == rd_ptr);

   assign push_ready = !full;
   assign pop_valid  = !empty;
   assign push_fire  = push_valid && push_ready;
   assign pop_fire   = pop_valid && pop_ready;
   assign pop_data   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_fire)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (rst && push_fire) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/cosim_loopback_buffered.sv
// Per-channel from-host -> FIFO -> resize -> to-host loopback with rx/tx message counters.
module cosim_loopback_buffered
   import cosim_loopback_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int IN_WIDTH    = 24,
   parameter int OUT_WIDTH   = 32,
   parameter int FIFO_DEPTH  = 4,
   parameter int SIGN_EXTEND = 0,
   parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             in_valid,
   output logic [NUM_CH-1:0]             in_ready,
   input  logic [NUM_CH*IN_WIDTH-1:0]    in_data,
   output logic [NUM_CH-1:0]             out_valid,
   input  logic [NUM_CH-1:0]             out_ready,
   output logic [NUM_CH*OUT_WIDTH-1:0]   out_data,
   output logic [NUM_CH*CNT_WIDTH-1:0]   rx_count,
   output logic [NUM_CH*CNT_WIDTH-1:0]   tx_count
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [IN_WIDTH-1:0]  head;
      logic                 push_ready;
      logic                 pop_valid;
      logic                 full;
      logic                 empty;
      logic [CNT_WIDTH-1:0] rx;
      logic [CNT_WIDTH-1:0] tx;

      cosim_sync_fifo #(
         .WIDTH (IN_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk        (clk),
         .rst        (rst),
         .push_valid (in_valid[i]),
         .push_ready (push_ready),
         .push_data  (in_data[i*IN_WIDTH +: IN_WIDTH]),
         .pop_valid  (pop_valid),
         .pop_ready  (out_ready[i]),
         .pop_data   (head),
         .full       (full),
         .empty      (empty)
      );

      // in_ready must drop the moment rst falls, not one edge later.
      assign in_ready[i]  = rst && push_ready;
      assign out_valid[i] = pop_valid;
      assign out_data[i*OUT_WIDTH +: OUT_WIDTH] =
         OUT_WIDTH'(resize_word(MAX_WORD_WIDTH'(head), IN_WIDTH, OUT_WIDTH, SIGN_EXTEND != 0));

      always_ff @(posedge clk) begin
         if (!rst) begin
            rx <= '0;
            tx <= '0;
         end else begin
            if (in_valid[i] && in_ready[i])   rx <= rx + CNT_WIDTH'(1);
            if (out_valid[i] && out_ready[i]) tx <= tx + CNT_WIDTH'(1);
         end
      end

      assign rx_count[i*CNT_WIDTH +: CNT_WIDTH] = rx;
      assign tx_count[i*CNT_WIDTH +: CNT_WIDTH] = tx;

      always_ff @(posedge clk) begin
         if (rst) assert (!(full && empty)) else $error("fifo ch%0d full and empty", i);
      end
   end

endmodule

// File: tb/tb_cosim_loopback_buffered.sv
// Directed bench: default 2-channel loopback plus sign-extend and truncate/4-bit-counter variants.
module tb_cosim_loopback_buffered;

   logic        clk;
   logic        rst;

   logic [1:0]  in_valid;
   logic [1:0]  in_ready;
   logic [47:0] in_data;
   logic [1:0]  out_valid;
   logic [1:0]  out_ready;
   logic [63:0] out_data;
   logic [31:0] rx_count;
   logic [31:0] tx_count;

   logic        sx_in_valid, sx_in_ready, sx_out_valid, sx_out_ready;
   logic [23:0] sx_in_data;
   logic [31:0] sx_out_data;
   logic [15:0] sx_rx_count, sx_tx_count;

   logic        tr_in_valid, tr_in_ready, tr_out_valid, tr_out_ready;
   logic [23:0] tr_in_data;
   logic [15:0] tr_out_data;
   logic [3:0]  tr_rx_count, tr_tx_count;

   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];

   int n_tests = 0;
   int n_fail  = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   cosim_loopback_buffered u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .rx_count(rx_count), .tx_count(tx_count)
   );

   cosim_loopback_buffered #(.NUM_CH(1), .SIGN_EXTEND(1)) u_sx (
      .clk(clk), .rst(rst),
      .in_valid(sx_in_valid), .in_ready(sx_in_ready), .in_data(sx_in_data),
      .out_valid(sx_out_valid), .out_ready(sx_out_ready), .out_data(sx_out_data),
      .rx_count(sx_rx_count), .tx_count(sx_tx_count)
   );

   cosim_loopback_buffered #(.NUM_CH(1), .OUT_WIDTH(16), .CNT_WIDTH(4)) u_tr (
      .clk(clk), .rst(rst),
      .in_valid(tr_in_valid), .in_ready(tr_in_ready), .in_data(tr_in_data),
      .out_valid(tr_out_valid), .out_ready(tr_out_ready), .out_data(tr_out_data),
      .rx_count(tr_rx_count), .tx_count(tr_tx_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
      step();
      step();
      rst = 1'b1;
      #1;
   endtask

   // scoreboard: every default-DUT delivery must match the head of its channel queue
   always @(negedge clk) begin
      if (rst) begin
         if (out_valid[0] && out_ready[0]) begin
            if (exp_q0.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL ch0_extra: got %0h expected no word", out_data[31:0]);
            end else check("ch0_data", {32'h0, out_data[31:0]}, {32'h0, exp_q0.pop_front()});
         end
         if (out_valid[1] && out_ready[1]) begin
            if (exp_q1.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL ch1_extra: got %0h expected no word", out_data[63:32]);
            end else check("ch1_data", {32'h0, out_data[63:32]}, {32'h0, exp_q1.pop_front()});
         end
      end
   end

   initial begin
      logic acc;
      rst = 1'b0;
      in_valid = '0; in_data = '0; out_ready = '0;
      sx_in_valid = 1'b0; sx_in_data = '0; sx_out_ready = 1'b0;
      tr_in_valid = 1'b0; tr_in_data = '0; tr_out_ready = 1'b0;

      // reset state
      step(); step();
      check("rst_out_valid", out_valid, 2'b00);
      check("rst_in_ready", in_ready, 2'b00);
      check("rst_rx", rx_count, 32'h0);
      check("rst_tx", tx_count, 32'h0);
      check("rst_sx_valid", sx_out_valid, 1'b0);
      rst = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 2'b11);

      // single word, ch0
      out_ready = 2'b01;
      in_valid = 2'b01;
      in_data[23:0] = 24'hABCDEF;
      exp_q0.push_back(32'h00ABCDEF);
      step();
      in_valid = 2'b00;
      check("single_valid", out_valid, 2'b01);
      check("single_data", out_data[31:0], 32'h00ABCDEF);
      check("single_rx", rx_count[15:0], 16'd1);
      step();
      check("single_tx", tx_count[15:0], 16'd1);
      check("single_empty", out_valid, 2'b00);

      // sign-extend and truncate variants
      sx_in_valid = 1'b1; sx_in_data = 24'h800001; sx_out_ready = 1'b1;
      tr_in_valid = 1'b1; tr_in_data = 24'h123456; tr_out_ready = 1'b1;
      step();
      sx_in_valid = 1'b0; tr_in_valid = 1'b0;
      check("sx_valid", sx_out_valid, 1'b1);
      check("sx_data", sx_out_data, 32'hFF800001);
      check("tr_data", tr_out_data, 16'h3456);
      step();
      check("sx_tx", sx_tx_count, 16'd1);

      // backpressure up to full, then drain
      do_reset();
      out_ready = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         in_valid[0] = 1'b1;
         in_data[23:0] = 24'(k);
         exp_q0.push_back(32'(k));
         check($sformatf("bp_ready_%0d", k), in_ready[0], 1'b1);
         step();
      end
      check("bp_full_ready", in_ready[0], 1'b0);
      check("bp_full_rx", rx_count[15:0], 16'd4);
      in_data[23:0] = 24'd5;
      exp_q0.push_back(32'd5);
      step();
      check("bp_hold_rx", rx_count[15:0], 16'd4);
      check("bp_hold_data", out_data[31:0], 32'd1);
      out_ready[0] = 1'b1;
      for (int c = 0; c < 12 && (exp_q0.size() != 0 || in_valid[0]); c++) begin
         acc = in_valid[0] && in_ready[0];
         step();
         if (acc) in_valid[0] = 1'b0;
      end
      check("bp_drain_q", exp_q0.size(), 0);
      check("bp_rx", rx_count[15:0], 16'd5);
      check("bp_tx", tx_count[15:0], 16'd5);
      out_ready = 2'b00;

      // streaming on ch1 across pointer wrap
      do_reset();
      out_ready = 2'b10;
      for (int k = 0; k < 20; k++) begin
         in_valid[1] = 1'b1;
         in_data[47:24] = 24'h5A0000 | 24'(k);
         exp_q1.push_back(32'h005A0000 | 32'(k));
         check($sformatf("stream_ready_%0d", k), in_ready[1], 1'b1);
         step();
         check($sformatf("stream_valid_%0d", k), out_valid[1], 1'b1);
      end
      in_valid[1] = 1'b0;
      step(); step();
      check("stream_q", exp_q1.size(), 0);
      check("stream_rx", rx_count[31:16], 16'd20);
      check("stream_tx", tx_count[31:16], 16'd20);
      check("stream_ch0_valid", out_valid[0], 1'b0);
      check("stream_ch0_cnt", {rx_count[15:0], tx_count[15:0]}, 32'h0);

      // reset mid-stream discards buffered words
      out_ready = 2'b00;
      for (int k = 0; k < 3; k++) begin
         in_valid[0] = 1'b1;
         in_data[23:0] = 24'hA10000 | 24'(k);
         step();
      end
      check("mid_rx_before", rx_count[15:0], 16'd3);
      rst = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
      in_data[23:0] = 24'h000055;
      #1;
      check("mid_in_ready", in_ready, 2'b00);
      step();
      check("mid_out_valid", out_valid, 2'b00);
      check("mid_in_ready2", in_ready, 2'b00);
      check("mid_cnt", {rx_count, tx_count}, 64'h0);
      in_valid = 2'b00;
      rst = 1'b1;
      #1;
      out_ready = 2'b01;
      in_valid[0] = 1'b1;
      in_data[23:0] = 24'h000007;
      exp_q0.push_back(32'h00000007);
      step();
      in_valid = 2'b00;
      check("mid_first_data", out_data[31:0], 32'h00000007);
      step();
      check("mid_rx", rx_count[15:0], 16'd1);
      check("mid_tx", tx_count[15:0], 16'd1);
      check("mid_q", exp_q0.size(), 0);

      // 4-bit counters wrap after 16 transfers
      do_reset();
      tr_out_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tr_in_valid = 1'b1;
         tr_in_data = 24'hAB0000 | 24'(k);
         step();
         if (k == 15) begin
            check("wrap_rx_16", tr_rx_count, 4'd0);
            check("wrap_tx_15", tr_tx_count, 4'd15);
         end
      end
      tr_in_valid = 1'b0;
      check("wrap_last_data", tr_out_data, 16'h0010);
      step(); step();
      check("wrap_rx", tr_rx_count, 4'd1);
      check("wrap_tx", tr_tx_count, 4'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
